mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-master memory request arbiter: IDLE -> ISSUE -> RESP, one transaction in flight.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority (port 1).

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 3'd0
`endif
`ifndef MEM_COUNT_BYTE
`define MEM_COUNT_BYTE 3'd1
`endif
`ifndef MEM_COUNT_HALF
`define MEM_COUNT_HALF 3'd2
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 3'd4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID 3'd0
`endif
`ifndef MEM_CODE_READ
`define MEM_CODE_READ 3'd1
`endif
`ifndef MEM_CODE_WRITE
`define MEM_CODE_WRITE 3'd2
`endif
`ifndef MEM_CODE_MISALIGNED
`define MEM_CODE_MISALIGNED 3'd3
`endif
`ifndef MEM_CODE_OUT_OF_BOUNDS
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`endif

module mem_req_arbiter (
  input  logic                    clk,
  input  logic                    areset,
  input  logic [`ADDR_W-1:0]      i_m0_req_addr,
  input  logic [`WORD_W-1:0]      i_m0_req_wr_data,
  input  logic                    i_m0_req_wr_en,
  input  logic [`MEM_COUNT_W-1:0] i_m0_req_count,
  input  logic [`ADDR_W-1:0]      i_m1_req_addr,
  input  logic [`WORD_W-1:0]      i_m1_req_wr_data,
  input  logic                    i_m1_req_wr_en,
  input  logic [`MEM_COUNT_W-1:0] i_m1_req_count,
  output logic [`WORD_W-1:0]      o_m0_res_rd_data,
  output logic [`MEM_CODE_W-1:0]  o_m0_res_code,
  output logic [`WORD_W-1:0]      o_m1_res_rd_data,
  output logic [`MEM_CODE_W-1:0]  o_m1_res_code,
  output logic                    o_m0_stall,
  output logic                    o_m1_stall,
  output logic [`ADDR_W-1:0]      o_req_addr,
  output logic [`WORD_W-1:0]      o_req_wr_data,
  output logic                    o_req_wr_en,
  output logic [`MEM_COUNT_W-1:0] o_req_count,
  input  logic [`WORD_W-1:0]      i_res_rd_data,
  input  logic [`MEM_CODE_W-1:0]  i_res_code
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q;
  logic   owner_q;
  logic   m0_req;
  logic   m1_req;
  logic   grant_m1;
  logic   resp_m0;
  logic   resp_m1;

  assign m0_req = (i_m0_req_count != `MEM_COUNT_NONE);
  assign m1_req = (i_m1_req_count != `MEM_COUNT_NONE);

`ifdef ARB_ROUND_ROBIN_EN
  // prio_q names the port that wins the next contention
  logic prio_q;

  assign grant_m1 = m1_req && (!m0_req || prio_q);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      prio_q <= 1'b0;
    end else if (state_q == StIdle && (m0_req || m1_req)) begin
      prio_q <= ~grant_m1;
    end
  end
`else
  assign grant_m1 = m1_req;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      o_req_addr    <= '0;
      o_req_wr_data <= '0;
      o_req_wr_en   <= 1'b0;
      o_req_count   <= `MEM_COUNT_NONE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_req || m1_req) begin
            state_q       <= StIssue;
            owner_q       <= grant_m1;
            o_req_addr    <= grant_m1 ? i_m1_req_addr    : i_m0_req_addr;
            o_req_wr_data <= grant_m1 ? i_m1_req_wr_data : i_m0_req_wr_data;
            o_req_wr_en   <= grant_m1 ? i_m1_req_wr_en   : i_m0_req_wr_en;
            o_req_count   <= grant_m1 ? i_m1_req_count   : i_m0_req_count;
          end
        end
        StIssue: begin
          state_q     <= StResp;
          o_req_count <= `MEM_COUNT_NONE;
        end
        // The owner still presents its old request here, so nothing is sampled.
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q     <= StIdle;
          o_req_count <= `MEM_COUNT_NONE;
        end
      endcase
    end
  end

  assign resp_m0 = (state_q == StResp) && !owner_q;
  assign resp_m1 = (state_q == StResp) && owner_q;

  always_comb begin
    o_m0_res_rd_data = '0;
    o_m0_res_code    = `MEM_CODE_INVALID;
    o_m1_res_rd_data = '0;
    o_m1_res_code    = `MEM_CODE_INVALID;
    if (resp_m0) begin
      o_m0_res_rd_data = i_res_rd_data;
      o_m0_res_code    = i_res_code;
    end
    if (resp_m1) begin
      o_m1_res_rd_data = i_res_rd_data;
      o_m1_res_code    = i_res_code;
    end
  end

  assign o_m0_stall = m0_req && !resp_m0;
  assign o_m1_stall = m1_req && !resp_m1;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (fixed-priority or ARB_ROUND_ROBIN_EN build).

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 3'd0
`endif
`ifndef MEM_COUNT_BYTE
`define MEM_COUNT_BYTE 3'd1
`endif
`ifndef MEM_COUNT_HALF
`define MEM_COUNT_HALF 3'd2
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 3'd4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID 3'd0
`endif
`ifndef MEM_CODE_READ
`define MEM_CODE_READ 3'd1
`endif
`ifndef MEM_CODE_WRITE
`define MEM_CODE_WRITE 3'd2
`endif
`ifndef MEM_CODE_MISALIGNED
`define MEM_CODE_MISALIGNED 3'd3
`endif
`ifndef MEM_CODE_OUT_OF_BOUNDS
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`endif

module tb_mem_req_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit FirstM1 = 1'b0;
`else
  localparam bit FirstM1 = 1'b1;
`endif

  logic                    clk = 1'b0;
  logic                    areset;
  logic [`ADDR_W-1:0]      m0_addr, m1_addr;
  logic [`WORD_W-1:0]      m0_wdata, m1_wdata;
  logic                    m0_wen, m1_wen;
  logic [`MEM_COUNT_W-1:0] m0_count, m1_count;
  logic [`WORD_W-1:0]      m0_rdata, m1_rdata;
  logic [`MEM_CODE_W-1:0]  m0_code, m1_code;
  logic                    m0_stall, m1_stall;
  logic [`ADDR_W-1:0]      req_addr;
  logic [`WORD_W-1:0]      req_wdata;
  logic                    req_wen;
  logic [`MEM_COUNT_W-1:0] req_count;
  logic [`WORD_W-1:0]      res_rdata;
  logic [`MEM_CODE_W-1:0]  res_code;

  int checks = 0;
  int errors = 0;

  mem_req_arbiter dut (
    .clk              (clk),
    .areset           (areset),
    .i_m0_req_addr    (m0_addr),
    .i_m0_req_wr_data (m0_wdata),
    .i_m0_req_wr_en   (m0_wen),
    .i_m0_req_count   (m0_count),
    .i_m1_req_addr    (m1_addr),
    .i_m1_req_wr_data (m1_wdata),
    .i_m1_req_wr_en   (m1_wen),
    .i_m1_req_count   (m1_count),
    .o_m0_res_rd_data (m0_rdata),
    .o_m0_res_code    (m0_code),
    .o_m1_res_rd_data (m1_rdata),
    .o_m1_res_code    (m1_code),
    .o_m0_stall       (m0_stall),
    .o_m1_stall       (m1_stall),
    .o_req_addr       (req_addr),
    .o_req_wr_data    (req_wdata),
    .o_req_wr_en      (req_wen),
    .o_req_count      (req_count),
    .i_res_rd_data    (res_rdata),
    .i_res_code       (res_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_m0_res(input string tag, input logic [31:0] data, input logic [2:0] code);
    chk({tag, "_m0_data"}, m0_rdata, data);
    chk({tag, "_m0_code"}, {29'd0, m0_code}, {29'd0, code});
  endtask

  task automatic chk_m1_res(input string tag, input logic [31:0] data, input logic [2:0] code);
    chk({tag, "_m1_data"}, m1_rdata, data);
    chk({tag, "_m1_code"}, {29'd0, m1_code}, {29'd0, code});
  endtask

  initial begin
    areset = 1'b1;
    m0_addr = '0; m0_wdata = '0; m0_wen = 1'b0; m0_count = `MEM_COUNT_NONE;
    m1_addr = '0; m1_wdata = '0; m1_wen = 1'b0; m1_count = `MEM_COUNT_NONE;
    res_rdata = 32'h1234_5678;
    res_code  = `MEM_CODE_READ;

    // Reset state; responses masked even though the peripheral drives READ.
    #3;
    chk("rst_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});
    chk("rst_addr", req_addr, 32'h0);
    chk("rst_wen", {31'd0, req_wen}, 32'd0);
    chk_m0_res("rst", 32'h0, `MEM_CODE_INVALID);
    chk_m1_res("rst", 32'h0, `MEM_CODE_INVALID);
    chk("rst_stall0_idle", {31'd0, m0_stall}, 32'd0);
    m0_count = `MEM_COUNT_WORD;
    #1;
    chk("rst_stall0_req", {31'd0, m0_stall}, 32'd1);
    step();
    chk("rst_hold_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});

    // Port 0 word read at 0x0 returning DEADBEEF/READ.
    m0_addr = 32'h0; m0_wen = 1'b0;
    res_rdata = 32'hDEAD_BEEF;
    areset = 1'b0;
    #1;
    chk("rd_idle_stall0", {31'd0, m0_stall}, 32'd1);
    step();
    chk("rd_iss_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_WORD});
    chk("rd_iss_addr", req_addr, 32'h0);
    chk("rd_iss_wen", {31'd0, req_wen}, 32'd0);
    chk("rd_iss_stall0", {31'd0, m0_stall}, 32'd1);
    chk_m0_res("rd_iss", 32'h0, `MEM_CODE_INVALID);
    step();
    chk("rd_resp_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});
    chk("rd_resp_stall0", {31'd0, m0_stall}, 32'd0);
    chk_m0_res("rd_resp", 32'hDEAD_BEEF, `MEM_CODE_READ);
    chk_m1_res("rd_resp", 32'h0, `MEM_CODE_INVALID);
    m0_count = `MEM_COUNT_NONE;
    step();
    chk_m0_res("rd_idle", 32'h0, `MEM_CODE_INVALID);
    chk("rd_idle_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});

    // Port 1 byte write 0xA5 at 0x3.
    m1_addr = 32'h3; m1_wdata = 32'hA5; m1_wen = 1'b1; m1_count = `MEM_COUNT_BYTE;
    step();
    chk("wr_iss_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_BYTE});
    chk("wr_iss_addr", req_addr, 32'h3);
    chk("wr_iss_data", req_wdata, 32'hA5);
    chk("wr_iss_wen", {31'd0, req_wen}, 32'd1);
    chk("wr_iss_stall1", {31'd0, m1_stall}, 32'd1);
    res_rdata = 32'h0; res_code = `MEM_CODE_WRITE;
    step();
    chk("wr_resp_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});
    chk("wr_resp_stall1", {31'd0, m1_stall}, 32'd0);
    chk_m1_res("wr_resp", 32'h0, `MEM_CODE_WRITE);
    chk_m0_res("wr_resp", 32'h0, `MEM_CODE_INVALID);
    m1_count = `MEM_COUNT_NONE; m1_wen = 1'b0;
    step();

    // Contention: both ports request in the same IDLE cycle.
    m0_addr = 32'h10; m0_count = `MEM_COUNT_WORD;
    m1_addr = 32'h20; m1_count = `MEM_COUNT_HALF;
    res_rdata = 32'h1111_2222; res_code = `MEM_CODE_READ;
    step();
    chk("arb1_iss_addr", req_addr, FirstM1 ? 32'h20 : 32'h10);
    chk("arb1_iss_stall0", {31'd0, m0_stall}, 32'd1);
    chk("arb1_iss_stall1", {31'd0, m1_stall}, 32'd1);
    step();
    chk("arb1_resp_stall0", {31'd0, m0_stall}, {31'd0, FirstM1});
    chk("arb1_resp_stall1", {31'd0, m1_stall}, {31'd0, !FirstM1});
    chk_m0_res("arb1_resp", FirstM1 ? 32'h0 : 32'h1111_2222,
               FirstM1 ? `MEM_CODE_INVALID : `MEM_CODE_READ);
    chk_m1_res("arb1_resp", FirstM1 ? 32'h1111_2222 : 32'h0,
               FirstM1 ? `MEM_CODE_READ : `MEM_CODE_INVALID);
    if (FirstM1) m1_count = `MEM_COUNT_NONE;
    else m0_count = `MEM_COUNT_NONE;
    step();
    chk("arb_idle_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});
    chk("arb_idle_stall0", {31'd0, m0_stall}, {31'd0, FirstM1});
    chk("arb_idle_stall1", {31'd0, m1_stall}, {31'd0, !FirstM1});
    step();
    chk("arb2_iss_addr", req_addr, FirstM1 ? 32'h10 : 32'h20);
    chk("arb2_iss_count", {29'd0, req_count},
        FirstM1 ? {29'd0, `MEM_COUNT_WORD} : {29'd0, `MEM_COUNT_HALF});
    res_rdata = 32'h3333_4444;
    step();
    chk_m0_res("arb2_resp", FirstM1 ? 32'h3333_4444 : 32'h0,
               FirstM1 ? `MEM_CODE_READ : `MEM_CODE_INVALID);
    chk_m1_res("arb2_resp", FirstM1 ? 32'h0 : 32'h3333_4444,
               FirstM1 ? `MEM_CODE_INVALID : `MEM_CODE_READ);
    m0_count = `MEM_COUNT_NONE; m1_count = `MEM_COUNT_NONE;
    step();

    // Port 1 half access at 0x1, peripheral reports MISALIGNED.
    m1_addr = 32'h1; m1_count = `MEM_COUNT_HALF;
    step();
    chk("mis_iss_addr", req_addr, 32'h1);
    res_rdata = 32'h0; res_code = `MEM_CODE_MISALIGNED;
    step();
    chk_m1_res("mis_resp", 32'h0, `MEM_CODE_MISALIGNED);
    chk_m0_res("mis_resp", 32'h0, `MEM_CODE_INVALID);
    m1_count = `MEM_COUNT_NONE;
    step();

    // Port 0 changes its address during ISSUE; the latched copy is kept.
    m0_addr = 32'h4; m0_wdata = 32'h55; m0_count = `MEM_COUNT_WORD;
    step();
    chk("hold_iss_addr", req_addr, 32'h4);
    m0_addr = 32'h8; m0_wdata = 32'h99;
    res_rdata = 32'hCAFE_0000; res_code = `MEM_CODE_OUT_OF_BOUNDS;
    #1;
    chk("hold_iss_addr2", req_addr, 32'h4);
    chk("hold_iss_data2", req_wdata, 32'h55);
    step();
    chk("hold_resp_addr", req_addr, 32'h4);
    chk("hold_resp_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});
    chk_m0_res("oob_resp", 32'hCAFE_0000, `MEM_CODE_OUT_OF_BOUNDS);
    step();
    chk("hold_idle_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});
    chk("hold_idle_stall0", {31'd0, m0_stall}, 32'd1);
    m0_count = `MEM_COUNT_NONE;
    step();

    // Reset pulsed during ISSUE drops the transaction; the master retries.
    m0_addr = 32'hC; m0_count = `MEM_COUNT_WORD;
    res_rdata = 32'hBEEF_0001; res_code = `MEM_CODE_READ;
    step();
    chk("rst_iss_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_WORD});
    areset = 1'b1;
    #1;
    chk("rst_async_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});
    chk("rst_async_addr", req_addr, 32'h0);
    chk("rst_async_stall0", {31'd0, m0_stall}, 32'd1);
    step();
    chk_m0_res("rst_drop", 32'h0, `MEM_CODE_INVALID);
    chk("rst_drop_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_NONE});
    areset = 1'b0;
    step();
    chk("retry_iss_count", {29'd0, req_count}, {29'd0, `MEM_COUNT_WORD});
    chk("retry_iss_addr", req_addr, 32'hC);
    chk_m0_res("retry_iss", 32'h0, `MEM_CODE_INVALID);
    step();
    chk_m0_res("retry_resp", 32'hBEEF_0001, `MEM_CODE_READ);
    chk("retry_resp_stall0", {31'd0, m0_stall}, 32'd0);
    m0_count = `MEM_COUNT_NONE;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
